// File: rtl/pong_ball_engine.sv
// Frame-stepped pong ball physics, paddle/wall collision, scoring and game-state sequencing.
// The ball advances once per rising edge of screen_end; all geometry comes from parameters.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | power-up hold, ball parked at serve, waits for start
//  SERVE | ball parked at serve for SERVE_FRAMES frames
//  PLAY  | ball moves each frame, bounces, paddle hits and goals
//  OVER  | a player reached WIN_SCORE, everything frozen until start
module pong_ball_engine #(
   parameter int X_W          = 10,
   parameter int Y_W          = 9,
   parameter int X_MAX        = 628,
   parameter int Y_MAX        = 463,
   parameter int X_INIT       = 320,
   parameter int Y_INIT       = 240,
   parameter int SPEED        = 1,
   parameter int PAD_HW       = 25,
   parameter int PAD_HH       = 33,
   parameter int WIN_SCORE    = 3,
   parameter int SCORE_W      = 4,
   parameter int SERVE_FRAMES = 60
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               screen_end,
   input  logic               start,
   input  logic [X_W-1:0]     p1_x,
   input  logic [Y_W-1:0]     p1_y,
   input  logic [X_W-1:0]     p2_x,
   input  logic [Y_W-1:0]     p2_y,
   output logic [X_W-1:0]     ball_x,
   output logic [Y_W-1:0]     ball_y,
   output logic               ball_xdir,
   output logic               ball_ydir,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [1:0]         winner,
   output logic [1:0]         state,
   output logic               goal_pulse
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] SERVE = 2'b01;
   localparam logic [1:0] PLAY  = 2'b10;
   localparam logic [1:0] OVER  = 2'b11;

   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   localparam logic [X_W:0]         SPD_X    = (X_W+1)'(SPEED);
   localparam logic [Y_W:0]         SPD_Y    = (Y_W+1)'(SPEED);
   localparam logic [X_W:0]         XMAX_E   = (X_W+1)'(X_MAX);
   localparam logic [Y_W:0]         YMAX_E   = (Y_W+1)'(Y_MAX);
   localparam logic [Y_W-1:0]       YMAX_N   = Y_W'(Y_MAX);
   localparam logic [X_W:0]         PHW_E    = (X_W+1)'(PAD_HW);
   localparam logic [Y_W:0]         PHH_E    = (Y_W+1)'(PAD_HH);
   localparam logic [X_W-1:0]       XINIT    = X_W'(X_INIT);
   localparam logic [Y_W-1:0]       YINIT    = Y_W'(Y_INIT);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [SCORE_W-1:0]   WIN      = SCORE_W'(WIN_SCORE);

   logic               screenEndQ;
   logic               tick;
   logic [CNT_W-1:0]   serveCnt;
   logic [X_W:0]       xExt, nextXCand;
   logic [Y_W:0]       yExt;
   logic [X_W:0]       p1xExt, p2xExt, p1Lo, p1Hi, p2Lo, p2Hi;
   logic [Y_W:0]       p1yExt, p2yExt, p1yLo, p1yHi, p2yLo, p2yHi;
   logic [Y_W-1:0]     nextY;
   logic               nextYdir;
   logic               hitP1, hitP2, goalP1, goalP2;
   logic [SCORE_W-1:0] p1Inc, p2Inc;

   always_comb begin
      tick   = screen_end & ~screenEndQ;
      xExt   = {1'b0, ball_x};
      yExt   = {1'b0, ball_y};
      p1xExt = {1'b0, p1_x};
      p2xExt = {1'b0, p2_x};
      p1yExt = {1'b0, p1_y};
      p2yExt = {1'b0, p2_y};

      // paddle boxes clamp at zero so a paddle near the edge never wraps high
      p1Lo  = (p1xExt < PHW_E) ? '0 : p1xExt - PHW_E;
      p1Hi  = p1xExt + PHW_E;
      p2Lo  = (p2xExt < PHW_E) ? '0 : p2xExt - PHW_E;
      p2Hi  = p2xExt + PHW_E;
      p1yLo = (p1yExt < PHH_E) ? '0 : p1yExt - PHH_E;
      p1yHi = p1yExt + PHH_E;
      p2yLo = (p2yExt < PHH_E) ? '0 : p2yExt - PHH_E;
      p2yHi = p2yExt + PHH_E;

      nextY    = ball_y;
      nextYdir = ball_ydir;
      if (!ball_ydir) begin
         if (yExt < SPD_Y) begin
            nextY    = '0;
            nextYdir = 1'b1;
         end else begin
            nextY = Y_W'(yExt - SPD_Y);
         end
      end else begin
         if (yExt + SPD_Y >= YMAX_E) begin
            nextY    = YMAX_N;
            nextYdir = 1'b0;
         end else begin
            nextY = Y_W'(yExt + SPD_Y);
         end
      end

      nextXCand = ball_xdir ? xExt + SPD_X : ((xExt < SPD_X) ? '0 : xExt - SPD_X);
      hitP1  = !ball_xdir && nextXCand >= p1Lo && nextXCand <= p1Hi
               && yExt >= p1yLo && yExt <= p1yHi;
      hitP2  = ball_xdir && nextXCand >= p2Lo && nextXCand <= p2Hi
               && yExt >= p2yLo && yExt <= p2yHi;
      goalP2 = !ball_xdir && !hitP1 && xExt <= SPD_X;
      goalP1 = ball_xdir && !hitP2 && xExt + SPD_X >= XMAX_E;
      p1Inc  = p1_score + 1'b1;
      p2Inc  = p2_score + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         screenEndQ <= 1'b0;
         serveCnt   <= '0;
         ball_x     <= XINIT;
         ball_y     <= YINIT;
         ball_xdir  <= 1'b1;
         ball_ydir  <= 1'b0;
         p1_score   <= '0;
         p2_score   <= '0;
         winner     <= 2'd0;
         state      <= IDLE;
         goal_pulse <= 1'b0;
      end else begin
         screenEndQ <= screen_end;
         goal_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SERVE;
                  serveCnt <= '0;
               end
            end
            SERVE: begin
               if (tick) begin
                  if (serveCnt == CNT_LAST) begin
                     state    <= PLAY;
                     serveCnt <= '0;
                  end else begin
                     serveCnt <= serveCnt + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (tick) begin
                  ball_y    <= nextY;
                  ball_ydir <= nextYdir;
                  if (hitP1) begin
                     ball_xdir <= 1'b1;
                  end else if (hitP2) begin
                     ball_xdir <= 1'b0;
                  end else if (goalP1 || goalP2) begin
                     goal_pulse <= 1'b1;
                     ball_x     <= XINIT;
                     ball_y     <= YINIT;
                     serveCnt   <= '0;
                     // serve heads toward whoever just conceded
                     if (goalP1) begin
                        p1_score  <= p1Inc;
                        ball_xdir <= 1'b1;
                        if (p1Inc == WIN) begin
                           state  <= OVER;
                           winner <= 2'd1;
                        end else begin
                           state <= SERVE;
                        end
                     end else begin
                        p2_score  <= p2Inc;
                        ball_xdir <= 1'b0;
                        if (p2Inc == WIN) begin
                           state  <= OVER;
                           winner <= 2'd2;
                        end else begin
                           state <= SERVE;
                        end
                     end
                  end else begin
                     ball_x <= nextXCand[X_W-1:0];
                  end
               end
            end
            default: begin
               if (start) begin
                  p1_score <= '0;
                  p2_score <= '0;
                  winner   <= 2'd0;
                  state    <= SERVE;
                  serveCnt <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: four instances with different geometry,
// each walked through serve, play, bounce, paddle-hit, goal and game-over scenarios.
module tb_pong_ball_engine;

   logic       clock = 1'b0;
   logic       rst [4];
   logic       se  [4];
   logic       st  [4];
   logic [9:0] bx  [4];
   logic [8:0] by  [4];
   logic       bxd [4];
   logic       byd [4];
   logic [3:0] s1  [4];
   logic [3:0] s2  [4];
   logic [1:0] win [4];
   logic [1:0] stt [4];
   logic       gp  [4];

   int checks = 0;
   int fails  = 0;

   always #5 clock = ~clock;

   // A: defaults with a short serve
   pong_ball_engine #(.SERVE_FRAMES(2)) dutA (
      .clock(clock), .reset(rst[0]), .screen_end(se[0]), .start(st[0]),
      .p1_x(10'd0), .p1_y(9'd0), .p2_x(10'd639), .p2_y(9'd0),
      .ball_x(bx[0]), .ball_y(by[0]), .ball_xdir(bxd[0]), .ball_ydir(byd[0]),
      .p1_score(s1[0]), .p2_score(s2[0]), .winner(win[0]), .state(stt[0]),
      .goal_pulse(gp[0]));

   // B: top-wall bounce
   pong_ball_engine #(.Y_INIT(1), .SERVE_FRAMES(1)) dutB (
      .clock(clock), .reset(rst[1]), .screen_end(se[1]), .start(st[1]),
      .p1_x(10'd0), .p1_y(9'd0), .p2_x(10'd639), .p2_y(9'd0),
      .ball_x(bx[1]), .ball_y(by[1]), .ball_xdir(bxd[1]), .ball_ydir(byd[1]),
      .p1_score(s1[1]), .p2_score(s2[1]), .winner(win[1]), .state(stt[1]),
      .goal_pulse(gp[1]));

   // C: right-paddle hit
   pong_ball_engine #(.X_INIT(304), .SERVE_FRAMES(1)) dutC (
      .clock(clock), .reset(rst[2]), .screen_end(se[2]), .start(st[2]),
      .p1_x(10'd0), .p1_y(9'd0), .p2_x(10'd330), .p2_y(9'd240),
      .ball_x(bx[2]), .ball_y(by[2]), .ball_xdir(bxd[2]), .ball_ydir(byd[2]),
      .p1_score(s1[2]), .p2_score(s2[2]), .winner(win[2]), .state(stt[2]),
      .goal_pulse(gp[2]));

   // D: goals and game over
   pong_ball_engine #(.X_INIT(627), .X_MAX(628), .WIN_SCORE(2), .SERVE_FRAMES(1)) dutD (
      .clock(clock), .reset(rst[3]), .screen_end(se[3]), .start(st[3]),
      .p1_x(10'd0), .p1_y(9'd0), .p2_x(10'd600), .p2_y(9'd400),
      .ball_x(bx[3]), .ball_y(by[3]), .ball_xdir(bxd[3]), .ball_ydir(byd[3]),
      .p1_score(s1[3]), .p2_score(s2[3]), .winner(win[3]), .state(stt[3]),
      .goal_pulse(gp[3]));

   task automatic checkEq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // one-cycle screen_end pulse; returns at the negedge after the update edge
   task automatic frameTick(input int d);
      @(negedge clock); se[d] = 1'b1;
      @(negedge clock); se[d] = 1'b0;
   endtask

   task automatic pulseStart(input int d);
      @(negedge clock); st[d] = 1'b1;
      @(negedge clock); st[d] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rst[i] = 1'b1; se[i] = 1'b0; st[i] = 1'b0;
      end
      repeat (3) @(negedge clock);
      for (int i = 0; i < 4; i++) rst[i] = 1'b0;

      checkEq("A reset x", bx[0], 320);
      checkEq("A reset y", by[0], 240);
      checkEq("A reset xdir", bxd[0], 1);
      checkEq("A reset ydir", byd[0], 0);
      checkEq("A reset state", stt[0], 0);
      checkEq("A reset p1", s1[0], 0);
      checkEq("A reset p2", s2[0], 0);
      checkEq("A reset winner", win[0], 0);
      checkEq("A reset goal", gp[0], 0);
      checkEq("D reset x", bx[3], 627);

      // A: ticks ignored in IDLE, two-frame serve, then one move
      frameTick(0);
      checkEq("A idle tick state", stt[0], 0);
      pulseStart(0);
      checkEq("A start state", stt[0], 1);
      frameTick(0);
      checkEq("A serve1 state", stt[0], 1);
      frameTick(0);
      checkEq("A serve2 state", stt[0], 2);
      checkEq("A serve2 x held", bx[0], 320);
      frameTick(0);
      checkEq("A play x", bx[0], 321);
      checkEq("A play y", by[0], 239);
      checkEq("A play goal", gp[0], 0);

      // A: reset together with a tick in PLAY
      @(negedge clock); rst[0] = 1'b1; se[0] = 1'b1;
      @(negedge clock);
      checkEq("A rst-tick x", bx[0], 320);
      checkEq("A rst-tick y", by[0], 240);
      checkEq("A rst-tick state", stt[0], 0);
      checkEq("A rst-tick goal", gp[0], 0);
      rst[0] = 1'b0; se[0] = 1'b0;

      // B: top wall
      pulseStart(1);
      frameTick(1);
      checkEq("B enter play", stt[1], 2);
      frameTick(1);
      checkEq("B y->0", by[1], 0);
      checkEq("B ydir still up", byd[1], 0);
      frameTick(1);
      checkEq("B bounce y", by[1], 0);
      checkEq("B bounce ydir", byd[1], 1);
      checkEq("B bounce x", bx[1], 322);
      frameTick(1);
      checkEq("B y after bounce", by[1], 1);
      @(negedge clock); se[1] = 1'b1;
      repeat (10) @(negedge clock);
      se[1] = 1'b0;
      @(negedge clock);
      checkEq("B long strobe y", by[1], 2);
      checkEq("B long strobe x", bx[1], 324);

      // C: right paddle
      pulseStart(2);
      frameTick(2);
      frameTick(2);
      checkEq("C hit x", bx[2], 304);
      checkEq("C hit xdir", bxd[2], 0);
      checkEq("C hit y", by[2], 239);
      frameTick(2);
      checkEq("C after hit x", bx[2], 303);
      checkEq("C after hit y", by[2], 238);
      pulseStart(2);
      checkEq("C start in play", stt[2], 2);

      // D: goals, game over, restart
      pulseStart(3);
      frameTick(3);
      checkEq("D enter play", stt[3], 2);
      frameTick(3);
      checkEq("D goal pulse", gp[3], 1);
      checkEq("D goal p1", s1[3], 1);
      checkEq("D goal p2", s2[3], 0);
      checkEq("D goal x", bx[3], 627);
      checkEq("D goal y", by[3], 240);
      checkEq("D goal state", stt[3], 1);
      checkEq("D goal xdir", bxd[3], 1);
      @(negedge clock);
      checkEq("D goal pulse width", gp[3], 0);
      frameTick(3);
      frameTick(3);
      checkEq("D win p1", s1[3], 2);
      checkEq("D win state", stt[3], 3);
      checkEq("D winner", win[3], 1);
      frameTick(3);
      frameTick(3);
      checkEq("D over x", bx[3], 627);
      checkEq("D over p1", s1[3], 2);
      checkEq("D over state", stt[3], 3);
      checkEq("D over goal", gp[3], 0);
      pulseStart(3);
      checkEq("D restart p1", s1[3], 0);
      checkEq("D restart winner", win[3], 0);
      checkEq("D restart state", stt[3], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Frame-stepped ball physics and scoring engine for the two-player pong game.
- Advances the ball once per rising edge of the screen-end strobe.
- Handles wall bounces, paddle hits and goals, keeps both scores, declares the winner and gates play through serve and game-over states.
- Outputs feed the regfile memory-mapped game registers and the VGA renderer; all geometry is parametrised rather than hard-coded.

Parameters:
- X_W, 10, x coordinate width.
- Y_W, 9, y coordinate width.
- X_MAX, 628, right goal line (ball x limit).
- Y_MAX, 463, bottom wall (ball y limit).
- X_INIT, 320, serve x.
- Y_INIT, 240, serve y.
- SPEED, 1, pixels moved per axis per frame.
- PAD_HW, 25, paddle half width.
- PAD_HH, 33, paddle half height.
- WIN_SCORE, 3, score that ends the game.
- SCORE_W, 4, score counter width.
- SERVE_FRAMES, 60, frames the ball is held at serve before play.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- screen_end  in  1  level signal from VGA; a rising edge marks one frame.
- start  in  1  leaves IDLE or OVER.
- p1_x  in  X_W  left paddle centre x.
- p1_y  in  Y_W  left paddle centre y.
- p2_x  in  X_W  right paddle centre x.
- p2_y  in  Y_W  right paddle centre y.
- ball_x  out  X_W  ball centre x.
- ball_y  out  Y_W  ball centre y.
- ball_xdir  out  1  1 = moving +x, 0 = moving -x.
- ball_ydir  out  1  1 = moving +y (down), 0 = moving -y (up).
- p1_score  out  SCORE_W  left player score.
- p2_score  out  SCORE_W  right player score.
- winner  out  2  0 none, 1 left player, 2 right player.
- state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 OVER.
- goal_pulse  out  1  one-cycle strobe on each goal.

Behaviour:
- Reset values:
  - ball = (X_INIT, Y_INIT), xdir = 1, ydir = 0.
  - scores = 0, winner = 0, state = IDLE.
  - goal_pulse = 0, serve counter = 0.
  - screen_end delay register = 0.
- Frame tick:
  - tick = screen_end & ~screen_end_q, where screen_end_q is screen_end registered.
  - Exactly one tick per rising edge, however long screen_end stays high.
  - Outputs change on the same clock edge that samples the tick (one-cycle latency from the first high sample).
- IDLE: ball held at serve. start → SERVE with counter cleared. Ticks are ignored.
- SERVE:
  - Ball held at (X_INIT, Y_INIT).
  - Counter increments per tick; on the tick where counter reaches SERVE_FRAMES-1 → PLAY, counter cleared.
  - SERVE_FRAMES = 1 means the first tick enters PLAY.
- PLAY, per tick:
  - All arithmetic is done at X_W+1 / Y_W+1 bits; no wrap-around.
  - Y axis:
    - Moving up with y < SPEED: y = 0, ydir = 1.
    - Moving down with y + SPEED >= Y_MAX: y = Y_MAX, ydir = 0.
    - Otherwise y ± SPEED.
  - X axis, candidate nx = x ± SPEED:
    - Paddle bounds are clamped at 0 (centre < half size gives a 0 lower bound).
    - Moving left, nx in [p1_x-PAD_HW, p1_x+PAD_HW] and y in [p1_y-PAD_HH, p1_y+PAD_HH]: paddle hit; x unchanged, xdir = 1.
    - Moving right, same test against p2: x unchanged, xdir = 0.
    - Otherwise, moving left with x <= SPEED: goal for p2.
    - Otherwise, moving right with x + SPEED >= X_MAX: goal for p1.
    - Otherwise x = nx.
  - Paddle hit has priority over goal in the same tick.
  - A y bounce and an x event in one tick are both applied.
- Goal:
  - goal_pulse = 1 for one cycle; the scorer's score increments.
  - Ball returns to serve; xdir points toward the conceding player; ydir is unchanged.
  - If the new score == WIN_SCORE: state → OVER, winner = 1 (p1) or 2 (p2).
  - Otherwise state → SERVE with counter cleared.
- OVER:
  - Ball and scores frozen; ticks ignored.
  - start clears scores and winner and enters SERVE; xdir, ydir and ball keep their values.
- Reset at any time, including mid-PLAY or mid-tick, overrides all other events and restores the reset values on the next edge.
- start outside IDLE or OVER is ignored.

Test Plan:
- Defaults, SERVE_FRAMES=2:
  - reset → ball (320,240), state 00, scores 0, winner 0.
  - start, then 2 ticks → state 10; one more tick → ball (321,239).
- Y_INIT=1, SERVE_FRAMES=1, paddles at (0,0) and (639,0):
  - ticks in PLAY → y goes 0 with ydir 1, then y=1.
  - screen_end held high 10 cycles counts as one tick.
- X_INIT=304, p2=(330,240):
  - first PLAY tick → x stays 304, xdir 0, y 239.
  - next tick → x 303.
- X_INIT=627, X_MAX=628, WIN_SCORE=2, p2=(600,400):
  - PLAY tick → goal_pulse 1 cycle, p1_score 1, ball (627,240), state 01, xdir 1.
  - After serve and next tick → p1_score 2, state 11, winner 1.
  - Further ticks change nothing; start → scores 0, winner 0, state 01.
- Reset asserted in the same cycle as a tick during PLAY → ball (320,240), state 00, no goal_pulse.
